prim_array_sequencer: RTL and testbench

Self-checking stimulus sequencer for the XOR/NOT primitive array used in the correctness evaluation circuits. It drives the array's `2*IO_PAIRS`-bit input with one vector at a time and waits a programmable settle interval. It then compares the array output against a closed-form golden model and accumulates pass/fail statistics. It sits beside the array under test and lets one host pulse run a complete regression.

---
 rtl/prim_array_sequencer_if.sv | 28 ++
 rtl/prim_array_sequencer.sv | 120 ++++++++++++
 tb/tb_prim_array_sequencer.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/prim_array_sequencer_if.sv
// Host/array bundle for prim_array_sequencer: run control, status and the
// stimulus/response vectors exchanged with the primitive array under test.
interface prim_array_sequencer_if #(
    parameter int IO_PAIRS = 1,
    parameter int CNT_W    = 16
);
    localparam int W = 2 * IO_PAIRS;

    logic             start;
    logic [CNT_W-1:0] num_vectors;
    logic [W-1:0]     arr_in;
    logic [W-1:0]     arr_out;
    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] err_count;
    logic [CNT_W-1:0] first_err_idx;

    modport master (
        output start, num_vectors, arr_out,
        input  arr_in, busy, done, pass, err_count, first_err_idx
    );

    modport slave (
        input  start, num_vectors, arr_out,
        output arr_in, busy, done, pass, err_count, first_err_idx
    );
endinterface

// File: rtl/prim_array_sequencer.sv
// Drives the XOR/NOT primitive array one vector at a time, waits SETTLE cycles,
// checks against the closed-form golden model. Define PRIM_SEQ_LFSR_EN for LFSR stimulus.
module prim_array_sequencer #(
    parameter int IO_PAIRS = 1,
    parameter int DEPTH    = 1,
    parameter int SETTLE   = 2,
    parameter int CNT_W    = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    prim_array_sequencer_if.slave  bus
);
    localparam int         W          = 2 * IO_PAIRS;
    localparam int         SW         = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);
    localparam logic [1:0] DEPTH_BITS = 2'(DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_DRIVE, S_SETTLE, S_CHECK, S_DONE} state_t;

    state_t           stateReg, stateNext;
    logic [CNT_W-1:0] countReg, idxReg, errReg, firstErrReg;
    logic [SW-1:0]    settleReg;
    logic [W-1:0]     arrInReg, stimVec, expOut;
    logic             passReg;
    logic             startAccept, lastVec, mismatch;

    assign startAccept = (stateReg == S_IDLE) && bus.start;
    assign lastVec     = (idxReg + CNT_W'(1)) == countReg;
    assign mismatch    = bus.arr_out != expOut;

    // Series stages collapse to a period-4 function of DEPTH, so only its low two bits matter.
    for (genvar gi = 0; gi < IO_PAIRS; gi++) begin : gGold
        assign expOut[2*gi]   = arrInReg[2*gi] ^ DEPTH_BITS[0];
        assign expOut[2*gi+1] = arrInReg[2*gi+1] ^ DEPTH_BITS[1] ^ (DEPTH_BITS[0] & arrInReg[2*gi]);
    end

`ifdef PRIM_SEQ_LFSR_EN
    logic [15:0] lfsrReg;
    logic        lfsrFb;

    assign lfsrFb = lfsrReg[15] ^ lfsrReg[13] ^ lfsrReg[12] ^ lfsrReg[10];

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                      lfsrReg <= 16'hACE1;
        else if (startAccept)         lfsrReg <= 16'hACE1;
        else if (stateReg == S_DRIVE) lfsrReg <= {lfsrReg[14:0], lfsrFb};
    end

    // Wider arrays see the 16-bit pattern repeated across the vector.
    for (genvar gi = 0; gi < W; gi++) begin : gStim
        assign stimVec[gi] = lfsrReg[gi % 16];
    end
`else
    assign stimVec = W'(idxReg);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) stateReg <= S_IDLE;
        else     stateReg <= stateNext;
    end

    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            S_IDLE:   if (bus.start) stateNext = (bus.num_vectors == '0) ? S_DONE : S_DRIVE;
            S_DRIVE:  stateNext = (SETTLE == 0) ? S_CHECK : S_SETTLE;
            S_SETTLE: if (settleReg == SW'(1)) stateNext = S_CHECK;
            S_CHECK:  stateNext = lastVec ? S_DONE : S_DRIVE;
            S_DONE:   stateNext = S_IDLE;
            default:  stateNext = S_IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (stateReg != S_IDLE);
        bus.done = (stateReg == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            countReg    <= '0;
            idxReg      <= '0;
            errReg      <= '0;
            firstErrReg <= '0;
            settleReg   <= '0;
            arrInReg    <= '0;
            passReg     <= 1'b0;
        end else begin
            case (stateReg)
                S_IDLE: if (bus.start) begin
                    countReg    <= bus.num_vectors;
                    idxReg      <= '0;
                    errReg      <= '0;
                    firstErrReg <= '0;
                    // An empty run goes straight to DONE, where pass must already read 1.
                    passReg     <= (bus.num_vectors == '0);
                end
                S_DRIVE: begin
                    arrInReg  <= stimVec;
                    settleReg <= SW'(SETTLE);
                end
                S_SETTLE: settleReg <= settleReg - SW'(1);
                S_CHECK: begin
                    if (mismatch) begin
                        if (errReg != '1) errReg <= errReg + CNT_W'(1);
                        if (errReg == '0) firstErrReg <= idxReg;
                    end
                    idxReg <= idxReg + CNT_W'(1);
                    // Resolved here so pass is valid during the DONE cycle itself.
                    if (lastVec) passReg <= (errReg == '0) && !mismatch;
                end
                default: ;
            endcase
        end
    end

    assign bus.arr_in        = arrInReg;
    assign bus.pass          = passReg;
    assign bus.err_count     = errReg;
    assign bus.first_err_idx = firstErrReg;
endmodule

// File: tb/tb_prim_array_sequencer.sv
// Directed bench for prim_array_sequencer: DEPTH=1 and DEPTH=2 instances, a
// stage-by-stage array model with optional stuck-at faults, and a stimulus scoreboard.
module tb_prim_array_sequencer;
    localparam int S = 2;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;
    int   sel = 0;
    int   faultMode = 0;
    logic [1:0] stimQ[$];

    always #5 clk = ~clk;

    prim_array_sequencer_if #(.IO_PAIRS(1), .CNT_W(16)) bus1 ();
    prim_array_sequencer_if #(.IO_PAIRS(1), .CNT_W(16)) bus2 ();

    prim_array_sequencer #(.IO_PAIRS(1), .DEPTH(1), .SETTLE(S), .CNT_W(16)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1)
    );
    prim_array_sequencer #(.IO_PAIRS(1), .DEPTH(2), .SETTLE(S), .CNT_W(16)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2)
    );

    // One primitive stage: lo' = ~lo, hi' = hi ^ lo; mode 1 = out[0] stuck 0, mode 2 = out[1] stuck 0.
    function automatic logic [1:0] arrayModel(input logic [1:0] v, input int depth, input int mode);
        logic lo, hi;
        lo = v[0];
        hi = v[1];
        for (int s = 0; s < depth; s++) begin
            hi = hi ^ lo;
            lo = ~lo;
        end
        if (mode == 1) lo = 1'b0;
        else if (mode == 2) hi = 1'b0;
        return {hi, lo};
    endfunction

    always_comb bus1.arr_out = arrayModel(bus1.arr_in, 1, faultMode);
    always_comb bus2.arr_out = arrayModel(bus2.arr_in, 2, 0);

    logic [1:0]  arrInS;
    logic        busyS, doneS, passS;
    logic [15:0] errS, firstS;
    assign arrInS = (sel != 0) ? bus2.arr_in        : bus1.arr_in;
    assign busyS  = (sel != 0) ? bus2.busy          : bus1.busy;
    assign doneS  = (sel != 0) ? bus2.done          : bus1.done;
    assign passS  = (sel != 0) ? bus2.pass          : bus1.pass;
    assign errS   = (sel != 0) ? bus2.err_count     : bus1.err_count;
    assign firstS = (sel != 0) ? bus2.first_err_idx : bus1.first_err_idx;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic setStart(input logic val);
        if (sel != 0) bus2.start = val;
        else          bus1.start = val;
    endtask

    task automatic runVectors(input int n, input int depth, input int mode, input int midStart);
        int expErr = 0;
        int expFirst = 0;
        int cyc = 0;
        logic [1:0] v;
`ifdef PRIM_SEQ_LFSR_EN
        logic [15:0] lf = 16'hACE1;
`endif
        for (int k = 0; k < n; k++) begin
`ifdef PRIM_SEQ_LFSR_EN
            v  = lf[1:0];
            lf = {lf[14:0], lf[15] ^ lf[13] ^ lf[12] ^ lf[10]};
`else
            v = 2'(k);
`endif
            stimQ.push_back(v);
            if (arrayModel(v, depth, mode) != arrayModel(v, depth, 0)) begin
                if (expErr == 0) expFirst = k;
                expErr++;
            end
        end
        @(negedge clk);
        setStart(1'b1);
        bus1.num_vectors = 16'(n);
        bus2.num_vectors = 16'(n);
        @(negedge clk);
        setStart(1'b0);
        cyc = 1;
        check("busy_after_start", 32'(busyS), 1);
        while (!doneS && cyc < 200) begin
            setStart(cyc == midStart);
            if (cyc % (S + 2) == 0) begin
                if (stimQ.size() == 0) check("sb_extra_vector", 32'(stimQ.size()), 1);
                else check("arr_in", 32'(arrInS), 32'(stimQ.pop_front()));
            end
            @(negedge clk);
            cyc++;
        end
        setStart(1'b0);
        check("done_cycle", 32'(cyc), 32'(n * (S + 2) + 1));
        check("done", 32'(doneS), 1);
        check("busy_in_done", 32'(busyS), 1);
        check("pass", 32'(passS), 32'(expErr == 0));
        check("err_count", 32'(errS), 32'(expErr));
        if (expErr != 0) check("first_err_idx", 32'(firstS), 32'(expFirst));
        check("sb_drained", 32'(stimQ.size()), 0);
        stimQ.delete();
        $display("run n=%0d depth=%0d mode=%0d done_at=%0d err=%0d first=%0d pass=%0b",
                 n, depth, mode, cyc, errS, firstS, passS);
        @(negedge clk);
        check("done_one_cycle", 32'(doneS), 0);
        check("busy_after_done", 32'(busyS), 0);
        check("pass_held", 32'(passS), 32'(expErr == 0));
    endtask

    initial begin
        rst = 1'b1;
        bus1.start = 1'b0;
        bus2.start = 1'b0;
        bus1.num_vectors = '0;
        bus2.num_vectors = '0;

        // Reset values, and a start pulse while reset is held.
        repeat (2) @(negedge clk);
        bus1.start = 1'b1;
        bus1.num_vectors = 16'd4;
        @(negedge clk);
        check("rst_arr_in", 32'(bus1.arr_in), 0);
        check("rst_busy", 32'(bus1.busy), 0);
        check("rst_done", 32'(bus1.done), 0);
        check("rst_pass", 32'(bus1.pass), 0);
        check("rst_err_count", 32'(bus1.err_count), 0);
        check("rst_first_err_idx", 32'(bus1.first_err_idx), 0);
        bus1.start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_busy", 32'(bus1.busy), 0);
        check("idle_done", 32'(bus1.done), 0);
        $display("reset idle check busy=%0b done=%0b", bus1.busy, bus1.done);

        runVectors(4, 1, 0, -1);
        faultMode = 1;
        runVectors(4, 1, 1, -1);
        faultMode = 2;
        runVectors(5, 1, 2, -1);
        faultMode = 0;
        sel = 1;
        runVectors(4, 2, 0, -1);
        sel = 0;
        runVectors(0, 1, 0, -1);
        runVectors(3, 1, 0, 5);

        // Abort during the SETTLE phase of vector 2.
        @(negedge clk);
        bus1.start = 1'b1;
        bus1.num_vectors = 16'd4;
        @(negedge clk);
        bus1.start = 1'b0;
        repeat (9) @(negedge clk);
        check("pre_abort_busy", 32'(bus1.busy), 1);
        rst = 1'b1;
        #1;
        check("abort_arr_in", 32'(bus1.arr_in), 0);
        check("abort_busy", 32'(bus1.busy), 0);
        check("abort_done", 32'(bus1.done), 0);
        check("abort_err_count", 32'(bus1.err_count), 0);
        check("abort_pass", 32'(bus1.pass), 0);
        repeat (3) begin
            @(negedge clk);
            check("abort_no_done", 32'(bus1.done), 0);
        end
        rst = 1'b0;
        $display("abort mid-run busy=%0b done=%0b", bus1.busy, bus1.done);
        runVectors(4, 1, 0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
